// File: rtl/cv32e40p_apu_responder.sv
// rtl/cv32e40p_apu_responder.sv - APU responder with single-cycle, MAC and iterative divide classes
//
// Purpose: accepts APU requests on req/gnt, runs one operation at a time and
// returns each result as a single-cycle rvalid pulse, in order.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   apu_req_i        request valid
//   apu_gnt_o        grant (req & idle), combinational
//   apu_operands_i   operands a=[0], b=[1], c=[2]
//   apu_op_i         opcode
//   apu_rvalid_o     one-cycle result pulse
//   apu_result_o     result, held between pulses
//   apu_flags_o      {NV, DZ, OF, 2'b00}, held between pulses
//   busy_o           high while an MAC/divide is in flight
module cv32e40p_apu_responder #(
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NUSFLAGS_CPU = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                apu_req_i,
  output logic                                apu_gnt_o,
  input  logic [APU_NARGS_CPU-1:0][31:0]      apu_operands_i,
  input  logic [APU_WOP_CPU-1:0]              apu_op_i,
  output logic                                apu_rvalid_o,
  output logic [31:0]                         apu_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]         apu_flags_o,
  output logic                                busy_o
);

  localparam logic [APU_WOP_CPU-1:0] OP_ADD  = APU_WOP_CPU'(0);
  localparam logic [APU_WOP_CPU-1:0] OP_SUB  = APU_WOP_CPU'(1);
  localparam logic [APU_WOP_CPU-1:0] OP_MIN  = APU_WOP_CPU'(2);
  localparam logic [APU_WOP_CPU-1:0] OP_MAX  = APU_WOP_CPU'(3);
  localparam logic [APU_WOP_CPU-1:0] OP_MAC  = APU_WOP_CPU'(4);
  localparam logic [APU_WOP_CPU-1:0] OP_DIVU = APU_WOP_CPU'(5);
  localparam logic [APU_WOP_CPU-1:0] OP_REMU = APU_WOP_CPU'(6);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

  state_e state_q, state_d;

  logic [5:0]                  cnt_q;
  logic                        rvalid_q;
  logic [31:0]                 result_q;
  logic [APU_NUSFLAGS_CPU-1:0] flags_q;
  logic [31:0]                 mac_q;
  logic [31:0]                 quot_q;
  logic [31:0]                 rem_q;
  logic [31:0]                 divisor_q;
  logic                        is_rem_q;

  logic [31:0] op_a, op_b, op_c;
  assign op_a = apu_operands_i[0];
  assign op_b = apu_operands_i[1];
  assign op_c = apu_operands_i[2];

  logic grant;
  logic is_mac;
  logic is_div;
  logic div_start;
  assign grant     = apu_req_i & rst_n & (state_q == IDLE);
  assign is_mac    = (apu_op_i == OP_MAC);
  assign is_div    = (apu_op_i == OP_DIVU) || (apu_op_i == OP_REMU);
  assign div_start = is_div && (op_b != 32'd0);

  // Single-cycle class result and flags
  logic [31:0]                 sc_result;
  logic [APU_NUSFLAGS_CPU-1:0] sc_flags;
  logic [31:0]                 sum, diff;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    sc_result = 32'd0;
    sc_flags  = '0;
    case (apu_op_i)
      OP_ADD: begin
        sc_result   = sum;
        sc_flags[2] = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
      end
      OP_SUB: begin
        sc_result   = diff;
        sc_flags[2] = (op_a[31] != op_b[31]) && (diff[31] != op_a[31]);
      end
      OP_MIN:  sc_result = ($signed(op_a) < $signed(op_b)) ? op_a : op_b;
      OP_MAX:  sc_result = ($signed(op_a) > $signed(op_b)) ? op_a : op_b;
      // Only reached with b==0; the nonzero case is taken by the DIV state
      OP_DIVU: begin
        sc_result   = 32'hFFFF_FFFF;
        sc_flags[3] = 1'b1;
      end
      OP_REMU: begin
        sc_result   = op_a;
        sc_flags[3] = 1'b1;
      end
      default: begin
        sc_result   = 32'd0;
        sc_flags[4] = 1'b1;
      end
    endcase
  end

  // One restoring-division step; the shifted remainder needs a 33rd bit
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] rem_next, quot_next;
  assign rem_sh    = {rem_q, quot_q[31]};
  assign rem_ge    = rem_sh >= {1'b0, divisor_q};
  assign rem_next  = rem_ge ? 32'(rem_sh - {1'b0, divisor_q}) : rem_sh[31:0];
  assign quot_next = {quot_q[30:0], rem_ge};

  // Counter value 1 marks the last busy cycle, so the pulse lands one cycle later
  logic last_cycle;
  assign last_cycle = (cnt_q == 6'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant && is_mac)         state_d = MUL;
        else if (grant && div_start) state_d = DIV;
      end
      MUL:     if (last_cycle) state_d = IDLE;
      DIV:     if (last_cycle) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 6'd0;
      rvalid_q  <= 1'b0;
      result_q  <= 32'd0;
      flags_q   <= '0;
      mac_q     <= 32'd0;
      quot_q    <= 32'd0;
      rem_q     <= 32'd0;
      divisor_q <= 32'd0;
      is_rem_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            if (is_mac) begin
              mac_q <= op_a * op_b + op_c;
              cnt_q <= 6'd2;
            end else if (div_start) begin
              quot_q    <= op_a;
              divisor_q <= op_b;
              rem_q     <= 32'd0;
              is_rem_q  <= (apu_op_i == OP_REMU);
              cnt_q     <= 6'd32;
            end else begin
              rvalid_q <= 1'b1;
              result_q <= sc_result;
              flags_q  <= sc_flags;
            end
          end
        end
        MUL: begin
          cnt_q <= cnt_q - 6'd1;
          if (last_cycle) begin
            rvalid_q <= 1'b1;
            result_q <= mac_q;
            flags_q  <= '0;
          end
        end
        DIV: begin
          cnt_q  <= cnt_q - 6'd1;
          rem_q  <= rem_next;
          quot_q <= quot_next;
          if (last_cycle) begin
            rvalid_q <= 1'b1;
            result_q <= is_rem_q ? rem_next : quot_next;
            flags_q  <= '0;
          end
        end
        default: cnt_q <= 6'd0;
      endcase
    end
  end

  assign apu_gnt_o    = grant;
  assign apu_rvalid_o = rvalid_q;
  assign apu_result_o = result_q;
  assign apu_flags_o  = flags_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_cv32e40p_apu_responder.sv
// tb/tb_cv32e40p_apu_responder.sv - directed self-checking bench for cv32e40p_apu_responder
module tb_cv32e40p_apu_responder;

  logic             clk;
  logic             rst_n;
  logic             apu_req_i;
  logic             apu_gnt_o;
  logic [2:0][31:0] apu_operands_i;
  logic [5:0]       apu_op_i;
  logic             apu_rvalid_o;
  logic [31:0]      apu_result_o;
  logic [4:0]       apu_flags_o;
  logic             busy_o;

  int total = 0;
  int bad   = 0;

  cv32e40p_apu_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apu_req_i      (apu_req_i),
    .apu_gnt_o      (apu_gnt_o),
    .apu_operands_i (apu_operands_i),
    .apu_op_i       (apu_op_i),
    .apu_rvalid_o   (apu_rvalid_o),
    .apu_result_o   (apu_result_o),
    .apu_flags_o    (apu_flags_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    apu_req_i         = req;
    apu_op_i          = op;
    apu_operands_i[0] = a;
    apu_operands_i[1] = b;
    apu_operands_i[2] = c;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 6'd0, 32'd5, 32'd7, 32'd0);
    tick();
    total++; if (apu_gnt_o !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", apu_gnt_o); end
    total++; if (apu_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", apu_rvalid_o); end
    total++; if (apu_result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", apu_result_o); end
    total++; if (apu_flags_o !== 5'd0) begin bad++; $display("FAIL reset_flags got=%h exp=0", apu_flags_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive(1'b1, 6'd0, 32'd5, 32'd7, 32'd0);
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL add_gnt got=%b exp=1", apu_gnt_o); end
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    total++; if (apu_rvalid_o !== 1'b1) begin bad++; $display("FAIL add_rvalid got=%b exp=1", apu_rvalid_o); end
    total++; if (apu_result_o !== 32'd12) begin bad++; $display("FAIL add_result got=%h exp=0000000c", apu_result_o); end
    total++; if (apu_flags_o !== 5'h00) begin bad++; $display("FAIL add_flags got=%h exp=00", apu_flags_o); end
    tick();
    total++; if (apu_rvalid_o !== 1'b0) begin bad++; $display("FAIL add_pulse_width got=%b exp=0", apu_rvalid_o); end
    total++; if (apu_result_o !== 32'd12) begin bad++; $display("FAIL add_hold got=%h exp=0000000c", apu_result_o); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 6'd0, 32'h7FFF_FFFF, 32'd1, 32'd0);
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt0 got=%b exp=1", apu_gnt_o); end
    tick();
    drive(1'b1, 6'd2, 32'hFFFF_FFFF, 32'd1, 32'd0);
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt1 got=%b exp=1", apu_gnt_o); end
    total++; if (apu_rvalid_o !== 1'b1) begin bad++; $display("FAIL b2b_rv0 got=%b exp=1", apu_rvalid_o); end
    total++; if (apu_result_o !== 32'h8000_0000) begin bad++; $display("FAIL ovf_result got=%h exp=80000000", apu_result_o); end
    total++; if (apu_flags_o !== 5'h04) begin bad++; $display("FAIL ovf_flags got=%h exp=04", apu_flags_o); end
    tick();
    drive(1'b1, 6'd1, 32'h8000_0000, 32'd1, 32'd0);
    total++; if (apu_rvalid_o !== 1'b1) begin bad++; $display("FAIL b2b_rv1 got=%b exp=1", apu_rvalid_o); end
    total++; if (apu_result_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL min_result got=%h exp=ffffffff", apu_result_o); end
    total++; if (apu_flags_o !== 5'h00) begin bad++; $display("FAIL min_flags got=%h exp=00", apu_flags_o); end
    tick();
    drive(1'b1, 6'd3, 32'hFFFF_FFFF, 32'd1, 32'd0);
    total++; if (apu_result_o !== 32'h7FFF_FFFF) begin bad++; $display("FAIL sub_result got=%h exp=7fffffff", apu_result_o); end
    total++; if (apu_flags_o !== 5'h04) begin bad++; $display("FAIL sub_flags got=%h exp=04", apu_flags_o); end
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    total++; if (apu_result_o !== 32'd1) begin bad++; $display("FAIL max_result got=%h exp=00000001", apu_result_o); end
    tick();
  endtask

  task automatic test_mac();
    drive(1'b1, 6'd4, 32'd3, 32'd4, 32'd10);
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL mac_gnt got=%b exp=1", apu_gnt_o); end
    tick();
    // Pending ADD request held through the MAC
    drive(1'b1, 6'd0, 32'd1, 32'd2, 32'd0);
    for (int i = 1; i <= 2; i++) begin
      total++; if (apu_gnt_o !== 1'b0) begin bad++; $display("FAIL mac_nogrant cyc=%0d got=%b exp=0", i, apu_gnt_o); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL mac_busy cyc=%0d got=%b exp=1", i, busy_o); end
      total++; if (apu_rvalid_o !== 1'b0) begin bad++; $display("FAIL mac_early cyc=%0d got=%b exp=0", i, apu_rvalid_o); end
      tick();
    end
    total++; if (apu_rvalid_o !== 1'b1) begin bad++; $display("FAIL mac_rvalid got=%b exp=1", apu_rvalid_o); end
    total++; if (apu_result_o !== 32'd22) begin bad++; $display("FAIL mac_result got=%h exp=00000016", apu_result_o); end
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL mac_pending_gnt got=%b exp=1", apu_gnt_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL mac_idle got=%b exp=0", busy_o); end
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    total++; if (apu_rvalid_o !== 1'b1 || apu_result_o !== 32'd3) begin bad++; $display("FAIL mac_follow rv=%b res=%h exp rv=1 res=00000003", apu_rvalid_o, apu_result_o); end
    tick();
  endtask

  task automatic test_div(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res);
    int lat;
    int busy_cnt;
    drive(1'b1, op, a, b, 32'd0);
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL div_gnt op=%0d got=%b exp=1", op, apu_gnt_o); end
    lat = 0;
    busy_cnt = 0;
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 40; i++) begin
      lat = i;
      if (apu_rvalid_o === 1'b1) break;
      if (busy_o === 1'b1) busy_cnt++;
      tick();
    end
    total++; if (lat !== 33) begin bad++; $display("FAIL div_latency op=%0d got=%0d exp=33", op, lat); end
    total++; if (busy_cnt !== 32) begin bad++; $display("FAIL div_busy op=%0d got=%0d exp=32", op, busy_cnt); end
    total++; if (apu_result_o !== exp_res) begin bad++; $display("FAIL div_result op=%0d got=%h exp=%h", op, apu_result_o, exp_res); end
    total++; if (apu_flags_o !== 5'h00) begin bad++; $display("FAIL div_flags op=%0d got=%h exp=00", op, apu_flags_o); end
    tick();
  endtask

  task automatic test_single_special(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] exp_res, input logic [4:0] exp_flags);
    drive(1'b1, op, a, b, 32'd0);
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL spec_gnt op=%0d got=%b exp=1", op, apu_gnt_o); end
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    total++; if (apu_rvalid_o !== 1'b1) begin bad++; $display("FAIL spec_rvalid op=%0d got=%b exp=1", op, apu_rvalid_o); end
    total++; if (apu_result_o !== exp_res) begin bad++; $display("FAIL spec_result op=%0d got=%h exp=%h", op, apu_result_o, exp_res); end
    total++; if (apu_flags_o !== exp_flags) begin bad++; $display("FAIL spec_flags op=%0d got=%h exp=%h", op, apu_flags_o, exp_flags); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL spec_busy op=%0d got=%b exp=0", op, busy_o); end
    tick();
  endtask

  task automatic test_reset_abort();
    int seen;
    drive(1'b1, 6'd5, 32'd100, 32'd7, 32'd0);
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
    total++; if (apu_rvalid_o !== 1'b0) begin bad++; $display("FAIL abort_rvalid got=%b exp=0", apu_rvalid_o); end
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (apu_rvalid_o === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_pulse got=%0d exp=0", seen); end
    drive(1'b1, 6'd0, 32'd2, 32'd3, 32'd0);
    total++; if (apu_gnt_o !== 1'b1) begin bad++; $display("FAIL abort_next_gnt got=%b exp=1", apu_gnt_o); end
    tick();
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0);
    total++; if (apu_rvalid_o !== 1'b1 || apu_result_o !== 32'd5) begin bad++; $display("FAIL abort_next_add rv=%b res=%h exp rv=1 res=00000005", apu_rvalid_o, apu_result_o); end
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    apu_req_i      = 1'b0;
    apu_op_i       = 6'd0;
    apu_operands_i = '0;
    tick();
    test_reset();
    test_add();
    test_back_to_back();
    test_mac();
    test_div(6'd5, 32'd100, 32'd7, 32'd14);
    test_div(6'd6, 32'd100, 32'd7, 32'd2);
    test_div(6'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
    test_single_special(6'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 5'h08);
    test_single_special(6'd6, 32'd9, 32'd0, 32'd9, 5'h08);
    test_single_special(6'h3F, 32'd9, 32'd4, 32'd0, 5'h10);
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
